// File: rtl/board_dot_scan_if.sv
// Bundle of board-state inputs and dot-matrix outputs for board_dot_scan.
// The master side loads a board; the slave side is the scanner.
interface board_dot_scan_if;
  logic [17:0] board_in;
  logic [8:0]  win_mask;
  logic        turn_o;
  logic        load;
  logic [9:0]  dot_row;
  logic [13:0] dot_col;
  logic        frame_done;

  modport master (
    output board_in, win_mask, turn_o, load,
    input  dot_row, dot_col, frame_done
  );

  modport slave (
    input  board_in, win_mask, turn_o, load,
    output dot_row, dot_col, frame_done
  );
endinterface

// File: rtl/board_dot_scan.sv
// Row-multiplexed 10x14 dot-matrix scanner for a 3x3 X/O board with a
// turn-indicator status row and blinking of winning cells.
module board_dot_scan #(
  parameter int TICK_DIV     = 2500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic             clk,
  input  logic             rst,
  board_dot_scan_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [17:0] board;
    logic [8:0]  mask;
    logic        turn;
  } dset_t;

  // One 4-column glyph row; MSB is the leftmost column of the cell.
  function automatic logic [3:0] glyph(input logic [1:0] code, input int gr);
    logic [3:0] g;
    g = 4'b0000;
    case (code)
      2'b01: g = (gr == 1) ? 4'b0110 : 4'b1001;
      2'b10: g = (gr == 1) ? 4'b1001 : 4'b0110;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  function automatic logic [13:0] render(input logic [3:0] row, input dset_t d,
                                         input logic ph);
    logic [13:0] cols;
    logic [3:0]  g;
    logic [1:0]  code;
    int          cr;
    int          gr;
    int          k;
    cols = '0;
    if (row == 4'd9) begin
      cols = d.turn ? 14'h3C00 : 14'h000F;
    end else begin
      cols[4] = 1'b1;
      cols[9] = 1'b1;
      cr = int'(row) / 3;
      gr = int'(row) % 3;
      for (int c = 0; c < 3; c++) begin
        k    = 3 * cr + c;
        code = d.board[2*k +: 2];
        g    = glyph(code, gr);
        if (ph && d.mask[k]) g = 4'b0000;
        for (int i = 0; i < 4; i++) cols[5*c + i] = g[3-i];
      end
    end
    return cols;
  endfunction

  logic             live;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       row_idx;
  logic             phase;
  logic [BF_W-1:0]  bf_cnt;
  dset_t            pending;
  dset_t            display;
  logic [9:0]       dot_row_p0;
  logic [13:0]      dot_col_p0;
  logic             frame_done_p0;

  logic             tick;
  logic             boundary;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       row_nxt;
  logic             phase_nxt;
  logic [BF_W-1:0]  bf_nxt;
  dset_t            in_set;
  dset_t            pending_nxt;
  dset_t            display_nxt;

  // Outputs are rendered from next-state row/display/phase, so row and
  // column data always switch on the same edge.
  always_comb begin
    in_set      = '{board: bus.board_in, mask: bus.win_mask, turn: bus.turn_o};
    tick        = live && (cnt == CNT_W'(TICK_DIV - 1));
    boundary    = tick && (row_idx == 4'd9);
    cnt_nxt     = (!live || tick) ? '0 : cnt + 1'b1;
    row_nxt     = row_idx;
    if (tick) row_nxt = (row_idx == 4'd9) ? 4'd0 : row_idx + 4'd1;
    pending_nxt = bus.load ? in_set : pending;
    display_nxt = boundary ? pending_nxt : display;
    phase_nxt   = phase;
    bf_nxt      = bf_cnt;
    if (boundary) begin
      if (bf_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        bf_nxt    = '0;
        phase_nxt = ~phase;
      end else begin
        bf_nxt    = bf_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live          <= 1'b0;
      cnt           <= '0;
      row_idx       <= '0;
      phase         <= 1'b0;
      bf_cnt        <= '0;
      pending       <= '0;
      display       <= '0;
      dot_row_p0    <= '0;
      dot_col_p0    <= '0;
      frame_done_p0 <= 1'b0;
    end else begin
      live          <= 1'b1;
      cnt           <= cnt_nxt;
      row_idx       <= row_nxt;
      phase         <= phase_nxt;
      bf_cnt        <= bf_nxt;
      pending       <= pending_nxt;
      display       <= display_nxt;
      dot_row_p0    <= 10'd1 << row_nxt;
      dot_col_p0    <= render(row_nxt, display_nxt, phase_nxt);
      frame_done_p0 <= boundary;
    end
  end

  assign bus.dot_row    = dot_row_p0;
  assign bus.dot_col    = dot_col_p0;
  assign bus.frame_done = frame_done_p0;

endmodule

// File: tb/tb_board_dot_scan.sv
// Directed bench for board_dot_scan with TICK_DIV=4, BLINK_FRAMES=2.
module tb_board_dot_scan;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   e;

  board_dot_scan_if bus ();

  board_dot_scan #(.TICK_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // e counts rising edges since reset release; samples taken on falling edges.
  task automatic goto(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic do_load(input logic [17:0] b, input logic [8:0] m, input logic t);
    bus.board_in = b;
    bus.win_mask = m;
    bus.turn_o   = t;
    bus.load     = 1'b1;
    goto(e + 1);
    bus.load     = 1'b0;
  endtask

  task automatic see(input string tag, input logic [9:0] r, input logic [13:0] c,
                     input logic fd);
    chk({tag, " row"}, 32'(bus.dot_row), 32'(r));
    chk({tag, " col"}, 32'(bus.dot_col), 32'(c));
    chk({tag, " fd"}, 32'(bus.frame_done), 32'(fd));
  endtask

  // First frame after release with an empty display, through the next row 0.
  task automatic check_empty_frame(input string tag);
    int r;
    for (int i = 1; i <= 41; i++) begin
      goto(i);
      r = (i - 1) / 4;
      if (i == 41)
        see($sformatf("%s e%0d", tag, i), 10'd1, 14'h0210, 1'b1);
      else
        see($sformatf("%s e%0d", tag, i), 10'd1 << r,
            (r < 9) ? 14'h0210 : 14'h000F, 1'b0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    e          = 0;
    rst          = 1'b1;
    bus.board_in = '0;
    bus.win_mask = '0;
    bus.turn_o   = 1'b0;
    bus.load     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    see("reset", 10'd0, 14'd0, 1'b0);
    rst = 1'b0;
    e   = 0;

    check_empty_frame("empty");
    goto(42);
    see("fd drop", 10'd1, 14'h0210, 1'b0);

    // Mid-frame load: cell 0 = X, cell 4 = O
    goto(45);
    do_load(18'h00201, 9'h000, 1'b0);
    goto(57);
    see("cur r4", 10'h010, 14'h0210, 1'b0);
    goto(81);
    see("nxt r0", 10'h001, 14'h0219, 1'b1);
    goto(85);
    see("nxt r1", 10'h002, 14'h0216, 1'b0);
    goto(97);
    see("nxt r4", 10'h010, 14'h0330, 1'b0);
    goto(117);
    see("nxt r9", 10'h200, 14'h000F, 1'b0);

    // Load on the boundary edge itself
    goto(120);
    do_load(18'h15555, 9'h000, 1'b0);
    see("bnd r0", 10'h001, 14'h2739, 1'b1);
    goto(125);
    see("bnd r1", 10'h002, 14'h1AD6, 1'b0);

    // Blink mask on the top cell row, O to move
    goto(126);
    do_load(18'h15555, 9'h007, 1'b1);
    goto(157);
    see("old r9", 10'h200, 14'h000F, 1'b0);
    goto(161);
    see("bl0 r0", 10'h001, 14'h2739, 1'b1);
    goto(197);
    see("turnO r9", 10'h200, 14'h3C00, 1'b0);
    goto(201);
    see("bl0b r0", 10'h001, 14'h2739, 1'b1);
    goto(241);
    see("bl1 r0", 10'h001, 14'h0210, 1'b1);
    goto(245);
    see("bl1 r1", 10'h002, 14'h0210, 1'b0);
    goto(253);
    see("bl1 r3", 10'h008, 14'h2739, 1'b0);
    goto(281);
    see("bl1b r0", 10'h001, 14'h0210, 1'b1);
    goto(301);
    see("bl1b r5", 10'h020, 14'h2739, 1'b0);
    goto(317);
    see("bl1b r9", 10'h200, 14'h3C00, 1'b0);
    goto(321);
    see("bl2 r0", 10'h001, 14'h2739, 1'b1);

    // Pending load then asynchronous reset during row 5
    goto(341);
    do_load(18'h2AAAA, 9'h000, 1'b1);
    see("pre rst r5", 10'h020, 14'h2739, 1'b0);
    rst = 1'b1;
    #1;
    see("async rst", 10'd0, 14'd0, 1'b0);
    @(negedge clk);
    see("hold rst", 10'd0, 14'd0, 1'b0);
    rst = 1'b0;
    e   = 0;
    check_empty_frame("post");
    goto(81);
    see("post f2 r0", 10'd1, 14'h0210, 1'b1);
    goto(117);
    see("post f2 r9", 10'h200, 14'h000F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/board_dot_scan.md
BOARD_DOT_SCAN -- requirements
Module: board_dot_scan

Interface
REQ-001 Parameter TICK_DIV, default 2500, meaning clk cycles each matrix row is held (minimum 2).
REQ-002 Parameter BLINK_FRAMES, default 32, meaning full frames per blink phase (minimum 1).
REQ-003 clk  input  1  system clock; the block SHALL use this single clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 board_in  input  18  cell k at bits [2k+1:2k], k = 3*r + c; 00 empty, 01 X, 10 O, 11 treated as empty.
REQ-006 win_mask  input  9  bit k set means cell k blinks.
REQ-007 turn_o  input  1  1 = O to move, 0 = X to move.
REQ-008 load  input  1  one-cycle pulse; board_in, win_mask and turn_o SHALL be captured on the edge where load=1.
REQ-009 dot_row  output  10  one-hot active-high row select; bit i is matrix row i, top row 0.
REQ-010 dot_col  output  14  active-high lit columns for the selected row; bit j is column j, left column 0.
REQ-011 frame_done  output  1  one-cycle pulse at the end of the row-9 dwell.

Function
REQ-012 The block SHALL hold two register sets (pending, display) of {board 18b, win_mask 9b, turn_o 1b}; load writes pending only.
REQ-013 At each frame boundary (row 9 -> row 0 transition), display SHALL copy pending.
REQ-014 If load coincides with a frame boundary, display SHALL take the load-cycle inputs directly, and pending SHALL take them too.
REQ-015 A prescaler SHALL count 0..TICK_DIV-1; the row index SHALL advance on the cycle the count equals TICK_DIV-1, wrapping 9 -> 0.
REQ-016 dot_row and dot_col SHALL be registered and SHALL change in the same cycle; no cycle SHALL show a new row with old column data.
REQ-017 Geometry: cell rows occupy matrix rows 0-2, 3-5 and 6-8; cell columns occupy cols 0-3, 5-8 and 10-13; cols 4 and 9 are grid lines.
REQ-018 Grid lines SHALL be lit in rows 0-8 regardless of board contents.
REQ-019 X glyph rows (MSB = leftmost col): 1001, 0110, 1001.
REQ-020 O glyph rows: 0110, 1001, 0110.
REQ-021 Empty cells and code 11 SHALL be 0000.
REQ-022 Row 9 is the status row; only cols 0-3 SHALL be lit when turn_o=0, and only cols 10-13 SHALL be lit when turn_o=1.
REQ-023 A blink phase bit SHALL toggle after every BLINK_FRAMES frame boundaries.
REQ-024 While the phase bit = 1, cells whose display win_mask bit is set SHALL render as 0000; grid lines and the status row SHALL be unaffected.
REQ-025 frame_done SHALL be 1 for exactly the one cycle in which the row-9 -> row-0 transition is registered.
REQ-026 Exactly one dot_row bit SHALL be set at all times after the first post-reset clock edge.

Reset
REQ-027 While rst=1: dot_row=0, dot_col=0, frame_done=0, prescaler=0, row index=0, blink phase=0, blink frame counter=0, pending=0, display=0.
REQ-028 On the first clk edge after rst deasserts: dot_row=10'b0000000001 and dot_col shows row 0 of the display set; with display=0, dot_col=14'b00001000010000 (cols 4 and 9).
REQ-029 Asserting rst mid-frame SHALL immediately force all REQ-027 values, discarding any pending load.

Verification (TICK_DIV=4, BLINK_FRAMES=2)
REQ-030 Reset release with no load -> row 0 held 4 cycles; rows 0-8 show only cols 4 and 9; row 9 shows cols 0-3; frame_done pulses once every 40 cycles.
REQ-031 Load board_in with cell 0=X and cell 4=O mid-frame, then check the current frame and the next one:
  - current frame: unchanged.
  - next frame, row 0: dot_col bits 0-3 = 1001 plus grid lines.
  - next frame, row 4: cols 5-8 = 1001 (O middle row).
REQ-032 Load asserted in the exact cycle of the row 9 -> 0 transition -> the new board appears in that row-0 output.
REQ-033 win_mask=9'b000000111, all cells X -> rows 0-2 cell glyphs visible for 2 frames, blank for 2 frames, then repeat; rows 3-8 always visible.
REQ-034 turn_o=1 loaded -> from the next frame, row 9 dot_col=14'b11110000000000 (cols 10-13).
REQ-035 rst pulsed during row 5 -> outputs zero asynchronously; after release the scan restarts at row 0 with an empty board, and frame_done does not pulse until 40 cycles later.
